audio_dac_tx: RTL and testbench

- Output stage of the effects chain: accepts 16-bit signed mono samples on a valid handshake and serialises them to the WM8731 DAC in I2S format.
- Generates BCLK and DACLRCK itself (codec in slave mode); the same sample goes to both channels.
- A 2-entry FIFO absorbs jitter between the effects pipeline and the frame clock.
- Underruns are handled deterministically and flagged; overflows are counted.

---
 rtl/audio_dac_tx.sv | 201 ++++++++++++++++++++
 tb/tb_audio_dac_tx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_tx.sv
// rtl/audio_dac_tx.sv - I2S transmitter for a WM8731 DAC in slave mode, with a 2-entry sample FIFO
// Optional build macro: DAC_TX_MUTE_ON_UNDERRUN_EN - an underrun frame outputs silence instead of repeating the last sample
module audio_dac_tx #(
    parameter int BCLK_DIV  = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [15:0] i_data,
    output logic        o_ready,
    output logic        o_bclk,
    output logic        o_daclrck,
    output logic        o_dacdat,
    output logic        o_underrun,
    output logic        o_overflow,
    output logic [7:0]  o_ovf_cnt
);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BW = $clog2(SLOT_BITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(SLOT_BITS - 1);

    typedef enum logic [1:0] {
        ST_RESET_WAIT,
        ST_LEFT,
        ST_RIGHT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] div;
    logic [BW-1:0] b;
    logic [BW-1:0] b_nxt;

    logic [15:0]   fifo_mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;

    logic [15:0]   sh;
    logic [15:0]   last_sample;
    logic [15:0]   load_val;
    logic [3:0]    bit_idx;
    logic          dac_bit;

    logic          fall_evt;
    logic          push;
    logic          pop;
    logic          load;
    logic          load_left;
    logic          underrun;

    assign o_ready  = (count != 2'd2);
    assign push     = i_valid && o_ready;
    // The registered toggle makes o_bclk go low on the next edge; that edge is the fall event.
    assign fall_evt = (div == DIV_LAST) && o_bclk;
    assign pop      = load_left && (count != 2'd0);
    assign underrun = load_left && (count == 2'd0);

    // Next-state logic for the slot sequencer and the bit counter within a slot.
    always_comb begin
        state_nxt = state;
        b_nxt     = b;
        load      = 1'b0;
        load_left = 1'b0;
        if (fall_evt) begin
            case (state)
                ST_RESET_WAIT: begin
                    // The first fall after reset is itself the first left-slot load (bit 0).
                    state_nxt = ST_LEFT;
                    b_nxt     = BW'(1);
                    load      = 1'b1;
                    load_left = 1'b1;
                end
                ST_LEFT, ST_RIGHT: begin
                    if (b == B_LAST) begin
                        b_nxt     = '0;
                        state_nxt = (state == ST_LEFT) ? ST_RIGHT : ST_LEFT;
                    end else begin
                        b_nxt = b + BW'(1);
                    end
                    if (b == '0) begin
                        load      = 1'b1;
                        load_left = (state == ST_LEFT);
                    end
                end
                default: begin
                    state_nxt = ST_RESET_WAIT;
                    b_nxt     = '0;
                end
            endcase
        end
    end

    // Select the sample for a left load and the serial bit for the current position.
    always_comb begin
        load_val = fifo_mem[rd_ptr];
        if (!pop) begin
`ifdef DAC_TX_MUTE_ON_UNDERRUN_EN
            load_val = 16'h0000;
`else
            load_val = last_sample;
`endif
        end
        bit_idx = 4'(16 - int'(b));
        dac_bit = 1'b0;
        if ((b != '0) && (int'(b) <= 16)) begin
            dac_bit = sh[bit_idx];
        end
    end

    // Bit-clock divider: o_bclk toggles each time div wraps.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div    <= '0;
            o_bclk <= 1'b0;
        end else if (div == DIV_LAST) begin
            div    <= '0;
            o_bclk <= ~o_bclk;
        end else begin
            div <= div + DW'(1);
        end
    end

    // Slot sequencer state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_RESET_WAIT;
            b     <= '0;
        end else begin
            state <= state_nxt;
            b     <= b_nxt;
        end
    end

    // Serial outputs change only at fall events; a load emits the I2S delay bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_daclrck  <= 1'b1;
            o_dacdat   <= 1'b0;
            o_underrun <= 1'b0;
            sh         <= '0;
        end else begin
            o_underrun <= underrun;
            if (load) begin
                o_daclrck <= ~load_left;
                o_dacdat  <= 1'b0;
                // The right slot reuses sh, which still holds the left sample.
                if (load_left) begin
                    sh <= load_val;
                end
            end else if (fall_evt) begin
                o_dacdat <= dac_bit;
            end
        end
    end

    // FIFO pointers, occupancy and the repeat-on-underrun sample.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            last_sample <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr      <= ~rd_ptr;
                last_sample <= fifo_mem[rd_ptr];
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    // FIFO storage; contents are discarded on reset by the pointer reset.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_data;
        end
    end

    // Dropped-sample pulse and saturating drop counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_overflow <= 1'b0;
            o_ovf_cnt  <= '0;
        end else begin
            o_overflow <= i_valid && !o_ready;
            if (i_valid && !o_ready && (o_ovf_cnt != 8'hFF)) begin
                o_ovf_cnt <= o_ovf_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_audio_dac_tx.sv
// tb/tb_audio_dac_tx.sv - scoreboard testbench for audio_dac_tx
module tb_audio_dac_tx;
    localparam int BCLK_DIV  = 2;
    localparam int SLOT_BITS = 32;
    localparam int FRAME     = 2 * SLOT_BITS * 2 * BCLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [15:0] data = '0;
    logic        ready;
    logic        bclk;
    logic        lrck;
    logic        dacdat;
    logic        underrun;
    logic        overflow;
    logic [7:0]  ovf_cnt;

    audio_dac_tx #(
        .BCLK_DIV  (BCLK_DIV),
        .SLOT_BITS (SLOT_BITS)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (valid),
        .i_data     (data),
        .o_ready    (ready),
        .o_bclk     (bclk),
        .o_daclrck  (lrck),
        .o_dacdat   (dacdat),
        .o_underrun (underrun),
        .o_overflow (overflow),
        .o_ovf_cnt  (ovf_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          words_seen = 0;
    int          m_ovf = 0;
    logic [15:0] mq [$];
    logic [15:0] exp_q [$];
    logic [15:0] m_last = '0;
    logic        prev_lrck = 1'b1;
    logic        prev_bclk = 1'b0;
    logic        rise_lrck = 1'b1;
    int          idx = 99;
    logic [15:0] word = '0;

    // Monitor: models FIFO pops at left loads and decodes the I2S stream on BCLK rises.
    always @(negedge clk) begin
        logic [15:0] v;
        logic [15:0] w;
        logic        exp_u;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_last    = '0;
            prev_lrck = 1'b1;
            prev_bclk = 1'b0;
            rise_lrck = 1'b1;
            idx       = 99;
            word      = '0;
        end else begin
            if (lrck == 1'b0 && prev_lrck == 1'b1) begin
                exp_u = (mq.size() == 0);
                checks++;
                if (underrun !== exp_u) begin
                    errors++;
                    $display("FAIL underrun_at_load got %b want %b", underrun, exp_u);
                end
                if (mq.size() != 0) begin
                    v = mq.pop_front();
                    m_last = v;
                end else begin
`ifdef DAC_TX_MUTE_ON_UNDERRUN_EN
                    v = 16'h0000;
`else
                    v = m_last;
`endif
                end
                exp_q.push_back(v);
                exp_q.push_back(v);
            end else begin
                checks++;
                if (underrun !== 1'b0) begin
                    errors++;
                    $display("FAIL underrun_spurious got %b want 0", underrun);
                end
            end
            if (bclk == 1'b1 && prev_bclk == 1'b0) begin
                if (lrck !== rise_lrck) idx = 0;
                else if (idx < 99) idx++;
                rise_lrck = lrck;
                if (idx >= 1 && idx <= 16) begin
                    word = {word[14:0], dacdat};
                    if (idx == 16) begin
                        words_seen++;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL word_unexpected got %h want none", word);
                        end else begin
                            w = exp_q.pop_front();
                            if (word !== w) begin
                                errors++;
                                $display("FAIL slot_word got %h want %h", word, w);
                            end
                        end
                    end
                end else if (idx < SLOT_BITS) begin
                    checks++;
                    if (dacdat !== 1'b0) begin
                        errors++;
                        $display("FAIL pad_bit idx %0d got %b want 0", idx, dacdat);
                    end
                end
            end
            prev_lrck = lrck;
            prev_bclk = bclk;
        end
    end

    task automatic do_reset();
        valid = 1'b0;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        m_ovf = 0;
        rst   = 1'b0;
    endtask

    // Called just after a negedge; drives one push cycle and checks ready/overflow/count.
    task automatic push_sample(input logic [15:0] d);
        logic er;
        er = (mq.size() < 2);
        checks++;
        if (ready !== er) begin
            errors++;
            $display("FAIL ready got %b want %b", ready, er);
        end
        valid = 1'b1;
        data  = d;
        @(posedge clk);
        if (er) mq.push_back(d);
        #1 valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (overflow !== !er) begin
            errors++;
            $display("FAIL overflow got %b want %b", overflow, !er);
        end
        if (!er && m_ovf < 255) m_ovf++;
        checks++;
        if (ovf_cnt !== 8'(m_ovf)) begin
            errors++;
            $display("FAIL ovf_cnt got %0d want %0d", ovf_cnt, m_ovf);
        end
    endtask

    task automatic wait_left_load();
        logic pl;
        logic seen;
        pl   = lrck;
        seen = 1'b0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            @(negedge clk);
            if (lrck == 1'b0 && pl == 1'b1) seen = 1'b1;
            pl = lrck;
        end
        #1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL left_load_timeout got none want load");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({bclk, lrck, dacdat, underrun, overflow, ready} !== 6'b010001 || ovf_cnt !== 8'd0) begin
            errors++;
            $display("FAIL %s got bclk%b lrck%b dat%b und%b ovf%b rdy%b cnt%0d want 0 1 0 0 0 1 0",
                     tag, bclk, lrck, dacdat, underrun, overflow, ready, ovf_cnt);
        end
    endtask

    task automatic check_words(input int start, input int need, input string tag);
        checks++;
        if (words_seen - start < need) begin
            errors++;
            $display("FAIL %s got %0d words want >= %0d", tag, words_seen - start, need);
        end
    endtask

    task automatic test_reset();
        int s;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset_values");
        @(negedge clk);
        rst = 1'b0;
        s = words_seen;
        @(posedge clk); #1;
        checks++;
        if (bclk !== 1'b0) begin errors++; $display("FAIL bclk_c1 got %b want 0", bclk); end
        @(posedge clk); #1;
        checks++;
        if (bclk !== 1'b1) begin errors++; $display("FAIL bclk_rise_c2 got %b want 1", bclk); end
        @(posedge clk); #1;
        checks++;
        if (lrck !== 1'b1) begin errors++; $display("FAIL lrck_c3 got %b want 1", lrck); end
        @(posedge clk); #1;
        checks++;
        if (bclk !== 1'b0 || lrck !== 1'b0 || underrun !== 1'b1) begin
            errors++;
            $display("FAIL first_load_c4 got bclk%b lrck%b und%b want 0 0 1", bclk, lrck, underrun);
        end
        repeat (2 * FRAME) @(negedge clk);
        check_words(s, 3, "reset_words");
    endtask

    task automatic test_first_push();
        int s;
        do_reset();
        #1;
        s = words_seen;
        push_sample(16'hA5C3);
        repeat (2 * FRAME) @(negedge clk);
        #1 check_words(s, 3, "first_push_words");
    endtask

    task automatic test_back_to_back();
        int s;
        do_reset();
        wait_left_load();
        s = words_seen;
        push_sample(16'h1234);
        push_sample(16'hBEEF);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b want 0", ready); end
        push_sample(16'h5A5A);
        checks++;
        if (ovf_cnt !== 8'd1) begin errors++; $display("FAIL b2b_ovf_cnt got %0d want 1", ovf_cnt); end
        repeat (3 * FRAME) @(negedge clk);
        #1 check_words(s, 5, "b2b_words");
    endtask

    task automatic test_underrun_hold();
        int s;
        do_reset();
        wait_left_load();
        s = words_seen;
        push_sample(16'h7FFF);
        repeat (3 * FRAME) @(negedge clk);
        #1 check_words(s, 5, "hold_words");
    endtask

    task automatic test_ovf_sat();
        do_reset();
        wait_left_load();
        for (int i = 0; i < 302; i++) push_sample(16'($urandom));
        checks++;
        if (ovf_cnt !== 8'd255) begin errors++; $display("FAIL ovf_saturate got %0d want 255", ovf_cnt); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        wait_left_load();
        push_sample(16'h1111);
        push_sample(16'h2222);
        n = 0;
        while (lrck !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        repeat (8 * 2 * BCLK_DIV) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_reset_values");
        repeat (3) @(negedge clk);
        m_ovf = 0;
        rst = 1'b0;
        repeat (2 * BCLK_DIV) @(posedge clk);
        #1;
        checks++;
        if (lrck !== 1'b0 || underrun !== 1'b1 || bclk !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_first_load got lrck%b und%b bclk%b want 0 1 0", lrck, underrun, bclk);
        end
        repeat (FRAME) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_back_to_back();
        test_underrun_hold();
        test_ovf_sat();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
